// File: rtl/wb_bcast_arbiter.sv
// rtl/wb_bcast_arbiter.sv - per-source FIFOs drained round-robin into one registered ROB writeback broadcast slot
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module wb_bcast_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ROB_ID_W  = 4,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_aL,
    input  logic                                  flush,
    input  logic [N_REQ-1:0]                      req_valid,
    output logic [N_REQ-1:0]                      req_ready,
    input  logic [N_REQ*ROB_ID_W-1:0]             req_rob_id,
    input  logic [N_REQ*DATA_W-1:0]               req_data,
    input  logic [N_REQ-1:0]                      req_flag,
    input  logic                                  bcast_ready,
    output logic                                  bcast_valid,
    output logic [ROB_ID_W-1:0]                   bcast_rob_id,
    output logic [DATA_W-1:0]                     bcast_data,
    output logic                                  bcast_flag,
    output logic [N_REQ-1:0]                      bcast_src,
    output logic [N_REQ*($clog2(BUF_DEPTH)+1)-1:0] buf_occupancy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int ENT_W = 1 + ROB_ID_W + DATA_W;

    typedef logic [ENT_W-1:0] entry_t;

    entry_t [N_REQ-1:0][BUF_DEPTH-1:0] mem_q, mem_d;
    logic [N_REQ-1:0][PTR_W-1:0]       wptr_q, wptr_d;
    logic [N_REQ-1:0][PTR_W-1:0]       rptr_q, rptr_d;
    logic [N_REQ-1:0][CNT_W-1:0]       cnt_q, cnt_d;

    logic                bcast_valid_q, bcast_valid_d;
    logic [ROB_ID_W-1:0] bcast_rob_id_q, bcast_rob_id_d;
    logic [DATA_W-1:0]   bcast_data_q, bcast_data_d;
    logic                bcast_flag_q, bcast_flag_d;
    logic [N_REQ-1:0]    bcast_src_q, bcast_src_d;

`ifndef WB_ARB_FIXED_PRIO_EN
    logic [RR_W-1:0]     rr_q, rr_d;
`endif

    logic [N_REQ-1:0]    fifo_empty;
    logic [N_REQ-1:0]    fifo_full;
    logic [N_REQ-1:0]    push_vec;
    logic [N_REQ-1:0]    pop_vec;
    logic                slot_free;
    logic                grant_found;
    logic [RR_W-1:0]     grant_idx;
    logic                pop_en;
    entry_t              head_entry;

    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_empty[i] = (cnt_q[i] == CNT_W'(0));
            fifo_full[i]  = (cnt_q[i] == CNT_W'(BUF_DEPTH));
        end
    end

    // Ready never depends on a same-cycle pop: a full FIFO stalls its producer.
    assign req_ready = ~fifo_full & {N_REQ{~flush}};
    assign slot_free = ~bcast_valid_q | bcast_ready;

    always_comb begin : grant_comb
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (!fifo_empty[i]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(i);
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && !fifo_empty[idx]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(idx);
            end
        end
`endif
    end

    // A flush discards the grant, so nothing is popped in that cycle.
    assign pop_en     = slot_free & grant_found & ~flush;
    assign head_entry = mem_q[grant_idx][rptr_q[grant_idx]];

    always_comb begin
        mem_d          = mem_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        cnt_d          = cnt_q;
        bcast_valid_d  = bcast_valid_q;
        bcast_rob_id_d = bcast_rob_id_q;
        bcast_data_d   = bcast_data_q;
        bcast_flag_d   = bcast_flag_q;
        bcast_src_d    = bcast_src_q;
        push_vec       = '0;
        pop_vec        = '0;
`ifndef WB_ARB_FIXED_PRIO_EN
        rr_d           = rr_q;
`endif

        for (int i = 0; i < N_REQ; i++) begin
            push_vec[i] = req_valid[i] & req_ready[i];
            pop_vec[i]  = pop_en & (grant_idx == RR_W'(i));
            if (push_vec[i]) begin
                mem_d[i][wptr_q[i]] = {req_flag[i],
                                       req_rob_id[i*ROB_ID_W +: ROB_ID_W],
                                       req_data[i*DATA_W +: DATA_W]};
                wptr_d[i] = wptr_q[i] + 1'b1;
            end
            if (pop_vec[i]) begin
                rptr_d[i] = rptr_q[i] + 1'b1;
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push_vec[i]) - CNT_W'(pop_vec[i]);
        end

        if (pop_en) begin
            bcast_valid_d  = 1'b1;
            bcast_flag_d   = head_entry[ENT_W-1];
            bcast_rob_id_d = head_entry[DATA_W +: ROB_ID_W];
            bcast_data_d   = head_entry[DATA_W-1:0];
            bcast_src_d    = N_REQ'(1) << grant_idx;
`ifndef WB_ARB_FIXED_PRIO_EN
            rr_d = (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end else if (bcast_ready) begin
            bcast_valid_d = 1'b0;
            bcast_src_d   = '0;
        end

        // Redirect flush wipes queued and in-flight results; RR pointer survives.
        if (flush) begin
            wptr_d        = '0;
            rptr_d        = '0;
            cnt_d         = '0;
            bcast_valid_d = 1'b0;
            bcast_src_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            mem_q          <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            bcast_valid_q  <= 1'b0;
            bcast_rob_id_q <= '0;
            bcast_data_q   <= '0;
            bcast_flag_q   <= 1'b0;
            bcast_src_q    <= '0;
        end else begin
            mem_q          <= mem_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cnt_q          <= cnt_d;
            bcast_valid_q  <= bcast_valid_d;
            bcast_rob_id_q <= bcast_rob_id_d;
            bcast_data_q   <= bcast_data_d;
            bcast_flag_q   <= bcast_flag_d;
            bcast_src_q    <= bcast_src_d;
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        buf_occupancy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            buf_occupancy[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign bcast_valid  = bcast_valid_q;
    assign bcast_rob_id = bcast_rob_id_q;
    assign bcast_data   = bcast_data_q;
    assign bcast_flag   = bcast_flag_q;
    assign bcast_src    = bcast_src_q;

endmodule

// File: tb/tb_wb_bcast_arbiter.sv
// tb/tb_wb_bcast_arbiter.sv - directed vector bench for wb_bcast_arbiter (round-robin build)
module tb_wb_bcast_arbiter;

    logic        clk;
    logic        rst_aL;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_rob_id;
    logic [63:0] req_data;
    logic [1:0]  req_flag;
    logic        bcast_ready;
    logic        bcast_valid;
    logic [3:0]  bcast_rob_id;
    logic [31:0] bcast_data;
    logic        bcast_flag;
    logic [1:0]  bcast_src;
    logic [3:0]  buf_occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_bcast_arbiter #(
        .N_REQ(2), .ROB_ID_W(4), .DATA_W(32), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .rst_aL(rst_aL), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_id(req_rob_id), .req_data(req_data), .req_flag(req_flag),
        .bcast_ready(bcast_ready), .bcast_valid(bcast_valid),
        .bcast_rob_id(bcast_rob_id), .bcast_data(bcast_data),
        .bcast_flag(bcast_flag), .bcast_src(bcast_src),
        .buf_occupancy(buf_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        flush;
        logic [1:0]  vld;
        logic [3:0]  id0;
        logic [31:0] d0;
        logic [3:0]  id1;
        logic [31:0] d1;
        logic [1:0]  fl;
        logic        brdy;
        logic        e_valid;
        logic [3:0]  e_id;
        logic [31:0] e_data;
        logic        e_flag;
        logic [1:0]  e_src;
        logic [1:0]  e_occ0;
        logic [1:0]  e_occ1;
        logic [1:0]  e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic fl_, logic [1:0] vld,
                                logic [3:0] id0, logic [31:0] d0,
                                logic [3:0] id1, logic [31:0] d1,
                                logic [1:0] flg, logic brdy,
                                logic ev, logic [3:0] eid, logic [31:0] ed, logic ef,
                                logic [1:0] es, logic [1:0] eo0, logic [1:0] eo1,
                                logic [1:0] er);
        vec_t v;
        v.name = name; v.flush = fl_; v.vld = vld;
        v.id0 = id0; v.d0 = d0; v.id1 = id1; v.d1 = d1; v.fl = flg; v.brdy = brdy;
        v.e_valid = ev; v.e_id = eid; v.e_data = ed; v.e_flag = ef; v.e_src = es;
        v.e_occ0 = eo0; v.e_occ1 = eo1; v.e_rdy = er;
        return v;
    endfunction

    function automatic vec_t idl(string name, logic brdy, logic ev, logic [3:0] eid,
                                 logic [31:0] ed, logic ef, logic [1:0] es,
                                 logic [1:0] eo0, logic [1:0] eo1, logic [1:0] er);
        return mk(name, 1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, brdy,
                  ev, eid, ed, ef, es, eo0, eo1, er);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        flush       = v.flush;
        req_valid   = v.vld;
        req_rob_id  = {v.id1, v.id0};
        req_data    = {v.d1, v.d0};
        req_flag    = v.fl;
        bcast_ready = v.brdy;
        #1;
        if (v.flush) chk({v.name, "_ready_during_flush"}, 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk({v.name, "_valid"}, 64'(bcast_valid), 64'(v.e_valid));
        chk({v.name, "_occ"}, 64'(buf_occupancy), 64'({v.e_occ1, v.e_occ0}));
        chk({v.name, "_ready"}, 64'(req_ready), 64'(v.e_rdy));
        if (v.e_valid) begin
            chk({v.name, "_rob_id"}, 64'(bcast_rob_id), 64'(v.e_id));
            chk({v.name, "_data"}, 64'(bcast_data), 64'(v.e_data));
            chk({v.name, "_flag"}, 64'(bcast_flag), 64'(v.e_flag));
            chk({v.name, "_src"}, 64'(bcast_src), 64'(v.e_src));
        end
    endtask

    initial begin
        // round-robin starting at requester 0
        vecs.push_back(mk("rr_push", 0, 2'b11, 4'd3, 32'h30, 4'd7, 32'h70, 2'b00, 1, 0, 0, 0, 0, 0, 1, 1, 2'b11));
        vecs.push_back(idl("rr_g0", 1, 1, 4'd3, 32'h30, 0, 2'b01, 0, 1, 2'b11));
        vecs.push_back(idl("rr_g1", 1, 1, 4'd7, 32'h70, 0, 2'b10, 0, 0, 2'b11));
        vecs.push_back(idl("rr_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // single LSU push
        vecs.push_back(mk("sp_push", 0, 2'b01, 4'd5, 32'hDEADBEEF, 4'd0, 32'd0, 2'b01, 1, 0, 0, 0, 0, 0, 1, 0, 2'b11));
        vecs.push_back(idl("sp_bcast", 1, 1, 4'd5, 32'hDEADBEEF, 1, 2'b01, 0, 0, 2'b11));
        vecs.push_back(idl("sp_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // pointer now at requester 1: ALU wins first
        vecs.push_back(mk("rr1_push", 0, 2'b11, 4'hA, 32'hA0, 4'hB, 32'hB0, 2'b10, 1, 0, 0, 0, 0, 0, 1, 1, 2'b11));
        vecs.push_back(idl("rr1_g1", 1, 1, 4'hB, 32'hB0, 1, 2'b10, 1, 0, 2'b11));
        vecs.push_back(idl("rr1_g0", 1, 1, 4'hA, 32'hA0, 0, 2'b01, 0, 0, 2'b11));
        vecs.push_back(idl("rr1_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // backpressure on ALU stream
        vecs.push_back(mk("bp_push1", 0, 2'b10, 0, 0, 4'd1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
        vecs.push_back(mk("bp_push2", 0, 2'b10, 0, 0, 4'd2, 32'h12, 0, 0, 1, 4'd1, 32'h11, 0, 2'b10, 0, 1, 2'b11));
        vecs.push_back(mk("bp_push3", 0, 2'b10, 0, 0, 4'd3, 32'h13, 0, 0, 1, 4'd1, 32'h11, 0, 2'b10, 0, 2, 2'b01));
        vecs.push_back(mk("bp_stall", 0, 2'b10, 0, 0, 4'd4, 32'h14, 0, 0, 1, 4'd1, 32'h11, 0, 2'b10, 0, 2, 2'b01));
        vecs.push_back(idl("bp_drain2", 1, 1, 4'd2, 32'h12, 0, 2'b10, 0, 1, 2'b11));
        vecs.push_back(idl("bp_drain3", 1, 1, 4'd3, 32'h13, 0, 2'b10, 0, 0, 2'b11));
        vecs.push_back(idl("bp_end", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // LSU FIFO wrap, one broadcast per cycle
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk($sformatf("wrap%0d", k), 0, 2'b01, 4'(8 + k), 32'(256 + 8 + k), 0, 0, 0, 1,
                              (k > 0), 4'(7 + k), 32'(256 + 7 + k), 0, 2'b01, 1, 0, 2'b11));
        end
        vecs.push_back(idl("wrap_last", 1, 1, 4'd13, 32'(256 + 13), 0, 2'b01, 0, 0, 2'b11));
        vecs.push_back(idl("wrap_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // fill both FIFOs and the slot, then flush with same-cycle pushes
        vecs.push_back(mk("fl_fill1", 0, 2'b11, 4'd1, 32'h201, 4'd2, 32'h302, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b11));
        vecs.push_back(mk("fl_fill2", 0, 2'b11, 4'd3, 32'h203, 4'd4, 32'h304, 0, 0, 1, 4'd2, 32'h302, 0, 2'b10, 2, 1, 2'b10));
        vecs.push_back(mk("fl_fill3", 0, 2'b10, 0, 0, 4'd5, 32'h305, 0, 0, 1, 4'd2, 32'h302, 0, 2'b10, 2, 2, 2'b00));
        vecs.push_back(mk("fl_flush", 1, 2'b11, 4'd6, 32'h206, 4'd7, 32'h307, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        vecs.push_back(idl("fl_after", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        vecs.push_back(mk("fl_repush", 0, 2'b11, 4'd8, 32'h208, 4'd9, 32'h309, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2'b11));
        vecs.push_back(idl("fl_g0", 1, 1, 4'd8, 32'h208, 0, 2'b01, 0, 1, 2'b11));
        vecs.push_back(idl("fl_g1", 1, 1, 4'd9, 32'h309, 0, 2'b10, 0, 0, 2'b11));
        vecs.push_back(idl("fl_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        // setup for mid-stream async reset
        vecs.push_back(mk("ar_push", 0, 2'b01, 4'hC, 32'hC0C0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11));
        vecs.push_back(mk("ar_push2", 0, 2'b01, 4'hD, 32'hD0D0, 0, 0, 0, 0, 1, 4'hC, 32'hC0C0, 0, 2'b01, 1, 0, 2'b11));

        rst_aL      = 1'b0;
        flush       = 1'b0;
        req_valid   = 2'b00;
        req_rob_id  = '0;
        req_data    = '0;
        req_flag    = 2'b00;
        bcast_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_aL = 1'b1;
        #1;
        chk("reset_valid", 64'(bcast_valid), 64'd0);
        chk("reset_rob_id", 64'(bcast_rob_id), 64'd0);
        chk("reset_data", 64'(bcast_data), 64'd0);
        chk("reset_flag", 64'(bcast_flag), 64'd0);
        chk("reset_src", 64'(bcast_src), 64'd0);
        chk("reset_occ", 64'(buf_occupancy), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'h3);

        foreach (vecs[i]) apply(vecs[i]);

        // bcast_valid=1 and FIFO0 holds one entry; drop reset between edges
        #2;
        rst_aL = 1'b0;
        #1;
        chk("areset_valid", 64'(bcast_valid), 64'd0);
        chk("areset_occ", 64'(buf_occupancy), 64'd0);
        chk("areset_src", 64'(bcast_src), 64'd0);
        chk("areset_rob_id", 64'(bcast_rob_id), 64'd0);
        @(posedge clk);
        #1;
        rst_aL = 1'b1;
        #1;
        chk("areset_ready", 64'(req_ready), 64'h3);
        apply(idl("areset_idle", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        apply(idl("areset_idle2", 1, 0, 0, 0, 0, 0, 0, 0, 2'b11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
